// File: rtl/uart_fifo_cfg.sv
// uart_fifo_cfg: host-side serial port. Parametrised 8-bit UART (optional
// even/odd parity, 16x oversampling) with first-word-fall-through byte FIFOs
// on both the transmit and receive side, plus sticky receive-error flags.
// DIV = CLK_HZ/(BAUD*16) must be an integer >= 1.

// Byte FIFO used on both sides. Read data falls through from the head entry.
module uart_fifo_cfg_fifo #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_rd_en,
    output logic [7:0]            o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0]            r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign w_full  = (r_count == (ADDR_WIDTH + 1)'(DEPTH));
    assign w_empty = (r_count == '0);
    // A read frees the slot a simultaneous write into a full FIFO needs;
    // a read of an empty FIFO never happens, so read+write on empty is write-only.
    assign w_do_rd = i_rd_en && !w_empty;
    assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH for free.
    // NOTE: state is updated with <= so every flop samples pre-edge values,
    // independent of statement order within or across blocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array write port.
    // NOTE: the array has no reset; its contents are only ever observed
    // behind a valid count, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;
endmodule

module uart_fifo_cfg #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int ADDR_WIDTH = 3,
    parameter int PARITY     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  tx,
    input  logic                  tx_en,
    input  logic [7:0]            tx_data,
    output logic                  tx_full,
    output logic [ADDR_WIDTH:0]   tx_count,
    input  logic                  rx,
    input  logic                  rx_en,
    output logic [7:0]            rx_data,
    output logic                  rx_empty,
    output logic [ADDR_WIDTH:0]   rx_count,
    output logic                  rx_overrun,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    input  logic                  err_clr
);
    localparam int DIV     = CLK_HZ / (BAUD * 16);
    localparam int TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam bit HAS_PAR = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Expected parity bit for a data byte: even -> ^d, odd -> ~^d.
    function automatic logic f_parity(input logic [7:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    // ------------------------------------------------------------------
    // Oversample tick: one pulse every DIV clocks, 16 ticks per bit.
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_W'(DIV - 1));

    // Free-running divider shared by both directions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic       w_tx_pop;
    logic [7:0] w_txf_head;
    logic       w_txf_empty;
    logic       w_rx_push;
    logic       w_rxf_full;

    uart_fifo_cfg_fifo #(.ADDR_WIDTH(ADDR_WIDTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (tx_en),
        .i_wr_data (tx_data),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_txf_head),
        .o_full    (tx_full),
        .o_empty   (w_txf_empty),
        .o_count   (tx_count)
    );

    logic [7:0] r_rx_shift;

    uart_fifo_cfg_fifo #(.ADDR_WIDTH(ADDR_WIDTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_rx_push),
        .i_wr_data (r_rx_shift),
        .i_rd_en   (rx_en),
        .o_rd_data (rx_data),
        .o_full    (w_rxf_full),
        .o_empty   (rx_empty),
        .o_count   (rx_count)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t     r_tx_state, w_tx_state_nxt;
    logic [3:0] r_tx_phase, w_tx_phase_nxt;
    logic [2:0] r_tx_bit,   w_tx_bit_nxt;
    logic [7:0] r_tx_shift, w_tx_shift_nxt;
    logic       r_tx_par,   w_tx_par_nxt;
    logic       w_tx_out;

    // TX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= S_IDLE;
            r_tx_phase <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_phase <= w_tx_phase_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
        end
    end

    // TX next state and line level. The line is decoded from registered
    // state only, so reset forces it high without waiting for a clock.
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_phase_nxt = r_tx_phase;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_tx_pop       = 1'b0;
        w_tx_out       = 1'b1;
        if (r_tx_state != S_IDLE && w_tick) w_tx_phase_nxt = r_tx_phase + 1'b1;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_phase_nxt = '0;
                if (w_tick && !w_txf_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_txf_head;
                    w_tx_par_nxt   = f_parity(w_txf_head);
                    w_tx_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_out = 1'b0;
                if (w_tick && r_tx_phase == 4'd15) begin
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_out = r_tx_shift[0];
                if (w_tick && r_tx_phase == 4'd15) begin
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_nxt   = r_tx_bit + 1'b1;
                    if (r_tx_bit == 3'd7) w_tx_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_tx_out = r_tx_par;
                if (w_tick && r_tx_phase == 4'd15) w_tx_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_tx_out = 1'b1;
                if (w_tick && r_tx_phase == 4'd15) begin
                    // Back-to-back frames: reload straight into START.
                    if (!w_txf_empty) begin
                        w_tx_pop       = 1'b1;
                        w_tx_shift_nxt = w_txf_head;
                        w_tx_par_nxt   = f_parity(w_txf_head);
                        w_tx_state_nxt = S_START;
                    end else begin
                        w_tx_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_tx_state_nxt = S_IDLE;
        endcase
    end

    assign tx = w_tx_out;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic       r_rx_meta;
    logic       r_rx_sync;
    state_t     r_rx_state, w_rx_state_nxt;
    logic [3:0] r_rx_phase, w_rx_phase_nxt;
    logic [2:0] r_rx_bit,   w_rx_bit_nxt;
    logic [7:0]             w_rx_shift_nxt;
    logic       r_rx_par,   w_rx_par_nxt;
    logic       w_rx_done;
    logic       w_stop_bad;
    logic       w_par_bad;
    logic       w_rx_good;
    logic       w_ovr_set;

    // Two-flop synchronizer; idles high so reset does not look like a start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= S_IDLE;
            r_rx_phase <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_phase <= w_rx_phase_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_par   <= w_rx_par_nxt;
        end
    end

    // RX next state: find the start-bit centre after 8 ticks, then sample
    // every 16 ticks. w_rx_done marks the stop-bit sample.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_phase_nxt = r_rx_phase;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_par_nxt   = r_rx_par;
        w_rx_done      = 1'b0;
        if (r_rx_state != S_IDLE && w_tick) w_rx_phase_nxt = r_rx_phase + 1'b1;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_phase_nxt = '0;
                if (!r_rx_sync) w_rx_state_nxt = S_START;
            end
            S_START: begin
                if (w_tick && r_rx_phase == 4'd7) begin
                    w_rx_phase_nxt = '0;
                    w_rx_bit_nxt   = '0;
                    // Line back high at the centre: a glitch, not a frame.
                    w_rx_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && r_rx_phase == 4'd15) begin
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + 1'b1;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick && r_rx_phase == 4'd15) begin
                    w_rx_par_nxt   = r_rx_sync;
                    w_rx_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick && r_rx_phase == 4'd15) begin
                    w_rx_done      = 1'b1;
                    w_rx_state_nxt = S_IDLE;
                end
            end
            default: w_rx_state_nxt = S_IDLE;
        endcase
    end

    assign w_stop_bad = w_rx_done && !r_rx_sync;
    assign w_par_bad  = w_rx_done && HAS_PAR && (r_rx_par != f_parity(r_rx_shift));
    assign w_rx_good  = w_rx_done && !w_stop_bad && !w_par_bad;
    assign w_rx_push  = w_rx_good && !w_rxf_full;
    assign w_ovr_set  = w_rx_good && w_rxf_full;

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_overrun    <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            if (w_ovr_set)    rx_overrun    <= 1'b1;
            else if (err_clr) rx_overrun    <= 1'b0;
            if (w_par_bad)    rx_parity_err <= 1'b1;
            else if (err_clr) rx_parity_err <= 1'b0;
            if (w_stop_bad)   rx_frame_err  <= 1'b1;
            else if (err_clr) rx_frame_err  <= 1'b0;
        end
    end
endmodule
